// File: rtl/swipt_drive_gen.sv
// N-phase SWIPT bridge drive generator.
// A sequential restoring divider turns a requested frequency into a period in
// clocks; a free-running counter then produces N_PH equally spaced drive pulses
// with a soft-start ramp and a dead-time clamp, all gated by swiptAlive.
module swipt_drive_gen #(
    parameter int unsigned FCLK_HZ    = 100_000_000,
    parameter int unsigned N_PH       = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEF_PERIOD = 2500,
    parameter int unsigned DEAD       = 10,
    parameter int unsigned RAMP_STEP  = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             swiptAlive,
    input  logic [31:0]      freq,
    input  logic             freq_load,
    input  logic [11:0]      l,
    output logic             busy,
    output logic             freq_err,
    output logic [CNT_W-1:0] period,
    output logic             cycle_start,
    output logic [N_PH-1:0]  SWIPT_OUT
);

    localparam int unsigned LOG2N = $clog2(N_PH);
    // Common comparison width wide enough for both the counter domain and the
    // 12-bit on-time domain, so mixed-width compares never truncate.
    localparam int unsigned MW = ((CNT_W > 13) ? CNT_W : 13) + 1;
    localparam logic [31:0] DIVIDEND = 32'(FCLK_HZ);
    localparam logic [32:0] MAX_Q    = (33'd1 << CNT_W) - 33'd1;
    localparam logic [31:0] MIN_Q    = 32'(2 * N_PH);

    // Period counter and drive state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pendValid_q, pendValid_d;
    logic [11:0]      onEff_q, onEff_d;
    logic             alive_q;
    logic [N_PH-1:0]  drive_q, drive_d;
    logic             cycStart_q, cycStart_d;

    // Divider state
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [4:0]       iter_q, iter_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      qd_q, qd_d;
    logic [31:0]      divisor_q, divisor_d;

    // Divider datapath helpers
    logic [32:0]      remShift;
    logic             qBit;
    logic [31:0]      remNext;
    logic [31:0]      qdNext;
    logic             divOk;

    // Boundary helpers
    logic [CNT_W-1:0] bndPeriod;
    logic [CNT_W-1:0] bndWidth;
    logic [CNT_W-1:0] bndOnMax;
    logic [12:0]      rampSum;
    logic [11:0]      rampSel;
    logic [CNT_W-1:0] phaseWidth;

    // One restoring-division step: shift in the next dividend bit, subtract
    // the divisor when it fits. The difference is below the divisor, so the
    // 32-bit wrap-around subtraction yields the exact remainder.
    always_comb begin
        remShift = {rem_q, qd_q[31]};
        qBit     = (remShift >= {1'b0, divisor_q});
        remNext  = qBit ? (remShift[31:0] - divisor_q) : remShift[31:0];
        qdNext   = {qd_q[30:0], qBit};
    end

    // Divider control: load on an accepted strobe, iterate 32 times, then
    // either publish the quotient as pending or flag it as out of range.
    always_comb begin
        busy_d    = busy_q;
        err_d     = err_q;
        iter_d    = iter_q;
        rem_d     = rem_q;
        qd_d      = qd_q;
        divisor_d = divisor_q;
        divOk     = 1'b0;
        if (busy_q) begin
            rem_d  = remNext;
            qd_d   = qdNext;
            iter_d = iter_q + 5'd1;
            if (iter_q == 5'd31) begin
                busy_d = 1'b0;
                if (({1'b0, qdNext} > MAX_Q) || (qdNext < MIN_Q)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0;
                    divOk = 1'b1;
                end
            end
        end else if (freq_load) begin
            if (freq == 32'd0) begin
                err_d = 1'b1;
            end else begin
                busy_d    = 1'b1;
                iter_d    = 5'd0;
                rem_d     = 32'd0;
                qd_d      = DIVIDEND;
                divisor_d = freq;
            end
        end
    end

    // Values that apply from the coming period: the pending period if one is
    // waiting, and the ramped on-time clamped by l and the dead-time window.
    always_comb begin
        bndPeriod = pendValid_q ? pend_q : period_q;
        bndWidth  = bndPeriod >> LOG2N;
        bndOnMax  = (bndWidth > CNT_W'(DEAD)) ? (bndWidth - CNT_W'(DEAD)) : '0;
        rampSum   = {1'b0, onEff_q} + 13'(RAMP_STEP);
        rampSel   = l;
        if (MW'(rampSum) < MW'(rampSel)) begin
            rampSel = 12'(rampSum);
        end
        if (MW'(bndOnMax) < MW'(rampSel)) begin
            rampSel = 12'(bndOnMax);
        end
    end

    // Period counter: held at zero while the link is down, restarts a period on
    // the wrap or on the first alive cycle, and swaps in any pending period there.
    always_comb begin
        cnt_d       = cnt_q;
        period_d    = period_q;
        pend_d      = pend_q;
        pendValid_d = pendValid_q;
        onEff_d     = onEff_q;
        if (!swiptAlive) begin
            cnt_d   = '0;
            onEff_d = '0;
        end else if (!alive_q || (cnt_q == (period_q - CNT_W'(1)))) begin
            cnt_d       = '0;
            period_d    = bndPeriod;
            pendValid_d = 1'b0;
            onEff_d     = rampSel;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (divOk) begin
            pend_d      = qdNext[CNT_W-1:0];
            pendValid_d = 1'b1;
        end
    end

    assign phaseWidth = period_q >> LOG2N;

    // Per-phase window test: distance of cnt past this phase's offset, taken
    // modulo the period, compared against the current on-time.
    for (genvar k = 0; k < N_PH; k++) begin : g_phase
        logic [CNT_W-1:0] phOffset;
        logic [CNT_W-1:0] phDist;
        assign phOffset   = CNT_W'(k) * phaseWidth;
        assign phDist     = (cnt_q >= phOffset) ? (cnt_q - phOffset)
                                                : (cnt_q + period_q - phOffset);
        assign drive_d[k] = swiptAlive && (MW'(phDist) < MW'(onEff_q));
    end

    // The cycle-start pulse is suppressed on the alive-rise cycle so that it
    // fires exactly once per period, on the first cycle cnt sits at zero.
    always_comb begin
        cycStart_d = swiptAlive && alive_q && (cnt_q == '0);
    end

    // State registers with synchronous reset; reset also aborts any division.
    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt_q       <= '0;
            period_q    <= CNT_W'(DEF_PERIOD);
            pend_q      <= '0;
            pendValid_q <= 1'b0;
            onEff_q     <= '0;
            alive_q     <= 1'b0;
            drive_q     <= '0;
            cycStart_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            iter_q      <= '0;
            rem_q       <= '0;
            qd_q        <= '0;
            divisor_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            pend_q      <= pend_d;
            pendValid_q <= pendValid_d;
            onEff_q     <= onEff_d;
            alive_q     <= swiptAlive;
            drive_q     <= drive_d;
            cycStart_q  <= cycStart_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            iter_q      <= iter_d;
            rem_q       <= rem_d;
            qd_q        <= qd_d;
            divisor_q   <= divisor_d;
        end
    end

    assign busy        = busy_q;
    assign freq_err    = err_q;
    assign period      = period_q;
    assign cycle_start = cycStart_q;
    assign SWIPT_OUT   = drive_q;

endmodule

// File: tb/tb_swipt_drive_gen.sv
// Self-checking bench for swipt_drive_gen: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_swipt_drive_gen;

    localparam int FCLK_HZ    = 100_000_000;
    localparam int N_PH       = 4;
    localparam int CNT_W      = 16;
    localparam int DEF_PERIOD = 2500;
    localparam int DEAD       = 10;
    localparam int RAMP_STEP  = 16;

    logic             clk = 1'b0;
    logic             nrst;
    logic             swiptAlive;
    logic [31:0]      freq;
    logic             freq_load;
    logic [11:0]      l;
    logic             busy;
    logic             freq_err;
    logic [CNT_W-1:0] period;
    logic             cycle_start;
    logic [N_PH-1:0]  SWIPT_OUT;

    int vecCount  = 0;
    int missCount = 0;

    // Behavioural model state, in plain integers
    int              mCnt    = 0;
    int              mP      = DEF_PERIOD;
    int              mOnEff  = 0;
    int              mPend   = 0;
    bit              mPendV  = 0;
    bit              mBusy   = 0;
    int              mLeft   = 0;
    longint          mQ      = 0;
    bit              mErr    = 0;
    bit              mAliveD = 0;
    logic [N_PH-1:0] mOut    = '0;
    bit              mCs     = 0;

    swipt_drive_gen #(
        .FCLK_HZ(FCLK_HZ), .N_PH(N_PH), .CNT_W(CNT_W),
        .DEF_PERIOD(DEF_PERIOD), .DEAD(DEAD), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .swiptAlive(swiptAlive),
        .freq(freq),
        .freq_load(freq_load),
        .l(l),
        .busy(busy),
        .freq_err(freq_err),
        .period(period),
        .cycle_start(cycle_start),
        .SWIPT_OUT(SWIPT_OUT)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count one comparison and report it when the values differ
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled
    task automatic modelStep();
        int w, onMax, newOn, off, d;
        bit completeOk;
        logic [N_PH-1:0] nextOut;
        if (nrst) begin
            mCnt = 0; mP = DEF_PERIOD; mOnEff = 0; mPend = 0; mPendV = 0;
            mBusy = 0; mLeft = 0; mErr = 0; mAliveD = 0; mOut = '0; mCs = 0;
            return;
        end
        w = mP / N_PH;
        nextOut = '0;
        for (int k = 0; k < N_PH; k++) begin
            off = k * w;
            d = (mCnt - off + mP) % mP;
            if (swiptAlive && d < mOnEff) nextOut[k] = 1'b1;
        end
        mCs  = swiptAlive && mAliveD && (mCnt == 0);
        mOut = nextOut;
        completeOk = 0;
        if (mBusy) begin
            mLeft--;
            if (mLeft == 0) begin
                mBusy = 0;
                if (mQ > longint'((1 << CNT_W) - 1) || mQ < 2 * N_PH) mErr = 1;
                else begin mErr = 0; completeOk = 1; end
            end
        end else if (freq_load) begin
            if (freq == 0) mErr = 1;
            else begin
                mBusy = 1;
                mLeft = 32;
                mQ = longint'(FCLK_HZ) / longint'(freq);
            end
        end
        if (!swiptAlive) begin
            mCnt = 0;
            mOnEff = 0;
        end else if (!mAliveD || mCnt == mP - 1) begin
            if (mPendV) begin mP = mPend; mPendV = 0; end
            w = mP / N_PH;
            onMax = (w > DEAD) ? w - DEAD : 0;
            newOn = mOnEff + RAMP_STEP;
            if (int'(l) < newOn) newOn = int'(l);
            if (onMax < newOn) newOn = onMax;
            mOnEff = newOn;
            mCnt = 0;
        end else begin
            mCnt++;
        end
        if (completeOk) begin mPend = int'(mQ); mPendV = 1; end
        mAliveD = swiptAlive;
    endtask

    // One clock: model follows the rising edge, outputs compared on the falling edge
    task automatic stepCycle(input bit doCheck);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        if (doCheck) begin
            checkOutput("SWIPT_OUT", 32'(SWIPT_OUT), 32'(mOut));
            checkOutput("cycle_start", 32'(cycle_start), 32'(mCs));
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("freq_err", 32'(freq_err), 32'(mErr));
            checkOutput("period", 32'(period), 32'(mP));
            checkOutput("overlap", 32'($countones(SWIPT_OUT) > 1), 32'(0));
        end
    endtask

    // Run n checked cycles with the current inputs
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) stepCycle(1'b1);
    endtask

    // Issue a one-cycle load strobe
    task automatic loadFreq(input logic [31:0] f);
        freq = f;
        freq_load = 1'b1;
        applyStimulus(1);
        freq_load = 1'b0;
    endtask

    initial begin
        int guard;
        int sel;
        nrst = 1'b1;
        swiptAlive = 1'b0;
        freq = '0;
        freq_load = 1'b0;
        l = 12'd250;
        repeat (3) stepCycle(1'b0);
        $display("[TB] reset state");
        applyStimulus(2);
        nrst = 1'b0;
        applyStimulus(5);

        $display("[TB] default period, ramp and phase spacing");
        swiptAlive = 1'b1;
        applyStimulus(3 * 2500 + 10);

        $display("[TB] 50 kHz load mid-period");
        loadFreq(32'd50000);
        applyStimulus(2 * 2500 + 100);

        $display("[TB] reject cases");
        loadFreq(32'd0);
        applyStimulus(5);
        loadFreq(32'd20);
        applyStimulus(40);
        loadFreq(32'd40000);
        applyStimulus(2600);

        $display("[TB] on-time clamp");
        loadFreq(32'd400000);
        l = 12'd1000;
        applyStimulus(2500 + 2000);
        l = 12'd250;

        $display("[TB] link drop at cnt 700");
        loadFreq(32'd50000);
        applyStimulus(40);
        guard = 0;
        while (mCnt != 700 && guard < 6000) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("reach_cnt700", 32'(guard < 6000), 32'(1));
        swiptAlive = 1'b0;
        applyStimulus(20);
        swiptAlive = 1'b1;
        applyStimulus(2 * 2000 + 100);

        $display("[TB] zero on-time");
        l = 12'd0;
        applyStimulus(2 * 2000 + 10);
        l = 12'd250;

        $display("[TB] reset during divide");
        loadFreq(32'd40000);
        applyStimulus(9);
        nrst = 1'b1;
        applyStimulus(1);
        nrst = 1'b0;
        loadFreq(32'd50000);
        applyStimulus(40);

        $display("[TB] randomized traffic");
        loadFreq(32'd1000000);
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 299) == 0 && !freq_load) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 7)       freq = $urandom_range(200_000, 5_000_000);
                else if (sel == 7) freq = 32'd0;
                else if (sel == 8) freq = $urandom_range(1, 1000);
                else               freq = $urandom_range(13_000_000, 100_000_000);
                freq_load = 1'b1;
            end else begin
                freq_load = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) l = 12'($urandom_range(0, 300));
            if ($urandom_range(0, 799) == 0) swiptAlive = ~swiptAlive;
            else if (!swiptAlive && $urandom_range(0, 19) == 0) swiptAlive = 1'b1;
            nrst = ($urandom_range(0, 5999) == 0);
            applyStimulus(1);
        end
        nrst = 1'b0;
        freq_load = 1'b0;
        applyStimulus(5);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/swipt_drive_gen.md
# swipt_drive_gen

Parametrised N-phase SWIPT bridge drive generator. It converts a requested drive frequency in Hz into a period in clock cycles using an on-chip sequential divider, and produces N_PH equally phase-shifted drive pulses with programmable on-time, dead-time clamp and soft-start ramp. Outputs are gated by the heartbeat-derived `swiptAlive`. It feeds the analog network's SWIPT_OUT inputs and generalises the fixed 4-output drive stage to any power-of-two phase count.

## Interface
- FCLK_HZ, 100_000_000: system clock frequency; divider dividend.
- N_PH, 4: number of phase outputs; power of two, at least 2.
- CNT_W, 16: period counter width; maximum period is 2^CNT_W-1.
- DEF_PERIOD, 2500: period after reset (40 kHz at 100 MHz).
- DEAD, 10: dead-time clocks subtracted from the per-phase window.
- RAMP_STEP, 16: soft-start on-time increment per period.

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous, active-high reset: 1 = reset, sampled on the rising clk edge.
- swiptAlive  in  1  link alive; 0 forces the outputs off.
- freq  in  32  requested frequency in Hz, sampled on freq_load.
- freq_load  in  1  one-cycle load strobe.
- l  in  12  target on-time in clocks, sampled at every period wrap.
- busy  out  1  divider running.
- freq_err  out  1  sticky; last load rejected.
- period  out  CNT_W  active period in clocks.
- cycle_start  out  1  one-cycle pulse when cnt==0.
- SWIPT_OUT  out  N_PH  drive outputs; bit k is phase k.

## Operation
- Derived values: P = active period; W = P >> log2(N_PH); offset_k = k*W; on_max = W-DEAD, floored at 0.
- Counter: cnt runs 0..P-1 and wraps to 0. It is held at 0 while swiptAlive=0.
- Period boundary (cnt==P-1, or the first cycle after swiptAlive rises):
  - A valid pending period, if present, becomes P.
  - l is resampled.
  - on_eff = min(on_eff+RAMP_STEP, l, on_max).
- Drive: SWIPT_OUT[k]=1 iff ((cnt-offset_k) mod P) < on_eff and swiptAlive=1.
- Divider: restoring unsigned division FCLK_HZ/freq, one quotient bit per cycle, 32 iterations.
- Load acceptance: freq_load is accepted only when busy=0. While busy=1 it is ignored, with no queuing and no error.
- Rejects:
  - freq==0: freq_err=1 on the next cycle; no divide starts.
  - Quotient > 2^CNT_W-1 or < 2*N_PH: freq_err=1 at completion; the result is discarded.
- Accepted completion: the quotient is latched as pending and freq_err clears.
- Consecutive loads: a second accepted completion before the wrap overwrites pending.
- swiptAlive=0: on the next cycle SWIPT_OUT=0, cnt=0 and on_eff=0. The divider and pending period keep running.
- Reset values: cnt=0, P=DEF_PERIOD, on_eff=0, pending invalid, busy=0, freq_err=0, cycle_start=0, SWIPT_OUT=0. Reset aborts any division.

## Timing
- freq_load accepted at edge t:
  - busy=1 for edges t+1..t+32.
  - busy=0 at t+33, with pending valid or freq_err=1.
- New P takes effect at the first wrap after pending becomes valid. `period` updates at that wrap.
- Output latency: SWIPT_OUT and cycle_start are registered from cnt and lag it by 1 cycle. The on-time is exactly on_eff clocks per phase per period.
- Phase k rises W*k clocks after phase 0.
- swiptAlive rise at edge t: cnt=0 at t+1 and the first period starts with on_eff=min(RAMP_STEP, l, on_max).
- If l changes mid-period, the new value is used only from the next wrap.
- If on_eff=0, outputs stay low and cycle_start still pulses.

## Test plan
- Defaults (FCLK_HZ=100e6, N_PH=4, swiptAlive=1, l=250):
  - P=2500; phase rising edges at cnt 0/625/1250/1875.
  - on_eff sequence: 16, 32, … 240, then 250 and held.
  - cycle_start every 2500 clocks.
- freq_load with freq=50000:
  - busy high exactly 32 cycles; period=2000 from the next wrap.
  - Phase offsets become 500; no partial period is truncated before the wrap.
- Reject cases:
  - freq=0 → freq_err=1 on the next cycle, period stays 2500.
  - freq=20 (quotient 5e6 > 65535) → freq_err=1 after 32 busy cycles, period unchanged.
  - freq=40000 afterwards → freq_err clears at completion.
- On-time clamp: l=1000 with P=2500 → on_eff saturates at 625-10=615; no two outputs are ever high simultaneously.
- swiptAlive dropped at cnt=700:
  - SWIPT_OUT=0 the next cycle.
  - On re-rise, cnt restarts at 0 and on_eff restarts at 16.
- Reset during busy:
  - nrst=1 at divide cycle 10 → busy=0 next cycle, period=2500, pending discarded.
  - freq_load in the cycle after release is accepted.
